// File: rtl/dispatch_ctrl.sv
// Rename-to-dispatch sequencing: instr0 ready/fire, ISQ and ROB credit tracking, flush/walk recovery FSM.
// Optional stall performance counters are built when DISP_PERF_CNT_EN is defined.
module dispatch_ctrl #(
  parameter int ISQ_DEPTH  = 8,
  parameter int ROB_DEPTH  = 64,
  parameter int FLUSH_HOLD = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         iru2isu_instr0_valid,
  output logic                         isu2iru_instr0_ready,
  input  logic [1:0]                   rob_state,
  input  logic                         flush_valid,
  input  logic                         isq_deq_valid,
  input  logic [1:0]                   rob_free_cnt,
  output logic                         disp_fire,
  output logic                         disp2rob_instr0_enq_valid,
  output logic                         disp2intisq_enq_valid,
  output logic [$clog2(ISQ_DEPTH):0]   isq_credit,
  output logic [$clog2(ROB_DEPTH):0]   rob_free,
  output logic [1:0]                   disp_state,
  output logic                         credit_err
`ifdef DISP_PERF_CNT_EN
  ,
  output logic [31:0]                  stall_isq_cnt,
  output logic [31:0]                  stall_rob_cnt
`endif
);

  localparam int ISQ_W  = $clog2(ISQ_DEPTH) + 1;
  localparam int ROB_W  = $clog2(ROB_DEPTH) + 1;
  localparam int HOLD_W = $clog2(FLUSH_HOLD + 1);

  localparam logic [ISQ_W:0]    ISQ_MAX  = (ISQ_W + 1)'(ISQ_DEPTH);
  localparam logic [ROB_W:0]    ROB_MAX  = (ROB_W + 1)'(ROB_DEPTH);
  localparam logic [HOLD_W-1:0] HOLD_LD  = HOLD_W'(FLUSH_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    WALK    = 2'd2,
    RECOVER = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic [HOLD_W-1:0]   hold_reg, hold_next;

  logic [ISQ_W-1:0]    isq_credit_reg, isq_credit_next;
  logic [ROB_W-1:0]    rob_free_reg, rob_free_next;
  logic                credit_err_reg, credit_err_next;

  logic [ISQ_W:0]      isq_sum;
  logic [ROB_W:0]      rob_sum;
  logic                isq_over, rob_over;
  logic                rob_idle;

  assign rob_idle = (rob_state == 2'b00);

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= RUN;
      hold_reg  <= '0;
    end else begin
      state_reg <= state_next;
      hold_reg  <= hold_next;
    end
  end

  // FSM next state; a flush request overrides every other transition
  always_comb begin
    state_next = state_reg;
    hold_next  = hold_reg;
    if (flush_valid) begin
      state_next = FLUSH;
      hold_next  = HOLD_LD;
    end else begin
      case (state_reg)
        FLUSH: begin
          if (hold_reg <= HOLD_ONE) begin
            hold_next  = '0;
            state_next = rob_idle ? RECOVER : WALK;
          end else begin
            hold_next = hold_reg - HOLD_ONE;
          end
        end
        WALK:    if (rob_idle) state_next = RECOVER;
        RECOVER: state_next = RUN;
        default: state_next = state_reg;
      endcase
    end
  end

  // FSM outputs; everything combinational is forced low while reset is held
  always_comb begin
    isu2iru_instr0_ready = ~reset & (state_reg == RUN) & ~flush_valid & rob_idle
                         & (isq_credit_reg != '0) & (rob_free_reg != '0);
    disp_fire                 = iru2isu_instr0_valid & isu2iru_instr0_ready;
    disp2rob_instr0_enq_valid = disp_fire;
    disp2intisq_enq_valid     = disp_fire;
  end

  // Credit arithmetic is one bit wider so an overflow can be seen before clamping
  always_comb begin
    isq_sum  = {1'b0, isq_credit_reg} + (ISQ_W + 1)'(isq_deq_valid) - (ISQ_W + 1)'(disp_fire);
    rob_sum  = {1'b0, rob_free_reg} + (ROB_W + 1)'(rob_free_cnt) - (ROB_W + 1)'(disp_fire);
    isq_over = ~flush_valid & (isq_sum > ISQ_MAX);
    rob_over = (rob_sum > ROB_MAX);

    if (flush_valid || isq_over) isq_credit_next = ISQ_W'(ISQ_DEPTH);
    else                         isq_credit_next = isq_sum[ISQ_W-1:0];

    if (rob_over) rob_free_next = ROB_W'(ROB_DEPTH);
    else          rob_free_next = rob_sum[ROB_W-1:0];

    credit_err_next = credit_err_reg | isq_over | rob_over;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      isq_credit_reg <= ISQ_W'(ISQ_DEPTH);
      rob_free_reg   <= ROB_W'(ROB_DEPTH);
      credit_err_reg <= 1'b0;
    end else begin
      isq_credit_reg <= isq_credit_next;
      rob_free_reg   <= rob_free_next;
      credit_err_reg <= credit_err_next;
    end
  end

  assign isq_credit = isq_credit_reg;
  assign rob_free   = rob_free_reg;
  assign credit_err = credit_err_reg;
  assign disp_state = state_reg;

`ifdef DISP_PERF_CNT_EN
  logic        stall_base;
  logic [31:0] stall_isq_reg, stall_rob_reg;

  assign stall_base = (state_reg == RUN) & iru2isu_instr0_valid & ~flush_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_isq_reg <= '0;
      stall_rob_reg <= '0;
    end else begin
      if (stall_base && isq_credit_reg == '0) stall_isq_reg <= stall_isq_reg + 32'd1;
      if (stall_base && rob_free_reg == '0)   stall_rob_reg <= stall_rob_reg + 32'd1;
    end
  end

  assign stall_isq_cnt = stall_isq_reg;
  assign stall_rob_cnt = stall_rob_reg;
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Self-checking bench for dispatch_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_dispatch_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iru2isu_instr0_valid = 1'b0;
  logic       isu2iru_instr0_ready;
  logic [1:0] rob_state = 2'b00;
  logic       flush_valid = 1'b0;
  logic       isq_deq_valid = 1'b0;
  logic [1:0] rob_free_cnt = 2'b00;
  logic       disp_fire;
  logic       disp2rob_instr0_enq_valid;
  logic       disp2intisq_enq_valid;
  logic [3:0] isq_credit;
  logic [6:0] rob_free;
  logic [1:0] disp_state;
  logic       credit_err;
`ifdef DISP_PERF_CNT_EN
  logic [31:0] stall_isq_cnt, stall_rob_cnt;
`endif

  int checks = 0;
  int failures = 0;

  // behavioural model: plain integers following the dispatch rules
  int m_isq, m_rob, m_mode, m_hold;
  bit m_err;

  always #5 clock = ~clock;

  dispatch_ctrl #(.ISQ_DEPTH(8), .ROB_DEPTH(64), .FLUSH_HOLD(2)) dut (
    .clock(clock),
    .reset(reset),
    .iru2isu_instr0_valid(iru2isu_instr0_valid),
    .isu2iru_instr0_ready(isu2iru_instr0_ready),
    .rob_state(rob_state),
    .flush_valid(flush_valid),
    .isq_deq_valid(isq_deq_valid),
    .rob_free_cnt(rob_free_cnt),
    .disp_fire(disp_fire),
    .disp2rob_instr0_enq_valid(disp2rob_instr0_enq_valid),
    .disp2intisq_enq_valid(disp2intisq_enq_valid),
    .isq_credit(isq_credit),
    .rob_free(rob_free),
    .disp_state(disp_state),
    .credit_err(credit_err)
`ifdef DISP_PERF_CNT_EN
    ,
    .stall_isq_cnt(stall_isq_cnt),
    .stall_rob_cnt(stall_rob_cnt)
`endif
  );

  function automatic bit model_ready();
    return (m_mode == 0) && !flush_valid && (rob_state == 2'b00) && (m_isq != 0) && (m_rob != 0);
  endfunction

  task automatic mdl_reset();
    m_isq = 8; m_rob = 64; m_mode = 0; m_hold = 0; m_err = 0;
  endtask

  task automatic set_in(input bit v, input bit f, input bit d, input logic [1:0] rs, input logic [1:0] rc);
    iru2isu_instr0_valid = v;
    flush_valid = f;
    isq_deq_valid = d;
    rob_state = rs;
    rob_free_cnt = rc;
  endtask

  // advance one clock and apply the dispatch rules to the model
  task automatic step();
    bit fire;
    int t;
    fire = iru2isu_instr0_valid && model_ready();
    @(posedge clock);
    if (flush_valid) m_isq = 8;
    else begin
      t = m_isq - int'(fire) + int'(isq_deq_valid);
      if (t > 8) begin t = 8; m_err = 1; end
      m_isq = t;
    end
    t = m_rob - int'(fire) + int'(rob_free_cnt);
    if (t > 64) begin t = 64; m_err = 1; end
    m_rob = t;
    if (flush_valid) begin
      m_mode = 1; m_hold = 2;
    end else if (m_mode == 1) begin
      m_hold = m_hold - 1;
      if (m_hold <= 0) begin m_hold = 0; m_mode = (rob_state != 2'b00) ? 2 : 3; end
    end else if (m_mode == 2) begin
      if (rob_state == 2'b00) m_mode = 3;
    end else if (m_mode == 3) m_mode = 0;
    #1;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 2'b00, 2'b00);
    reset = 1'b1;
    mdl_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(1, 0, 0, 2'b00, 2'b00);
    #1;
    checks++; if (isu2iru_instr0_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %0b exp 0", isu2iru_instr0_ready); end
    checks++; if (disp_fire !== 1'b0) begin failures++; $display("FAIL reset_fire: got %0b exp 0", disp_fire); end
    do_reset();
    checks++; if (isq_credit !== 4'd8) begin failures++; $display("FAIL reset_isq: got %0d exp 8", isq_credit); end
    checks++; if (rob_free !== 7'd64) begin failures++; $display("FAIL reset_rob: got %0d exp 64", rob_free); end
    checks++; if (disp_state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d exp 0", disp_state); end
    checks++; if (credit_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %0b exp 0", credit_err); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_in(1, 0, 0, 2'b00, 2'b00);
      #1;
      checks++; if (isq_credit !== 4'(8 - i)) begin failures++; $display("FAIL fill_isq[%0d]: got %0d exp %0d", i, isq_credit, 8 - i); end
      checks++; if (disp_fire !== 1'b1) begin failures++; $display("FAIL fill_fire[%0d]: got %0b exp 1", i, disp_fire); end
      checks++; if ({disp2rob_instr0_enq_valid, disp2intisq_enq_valid} !== 2'b11) begin failures++; $display("FAIL fill_enq[%0d]: got %b exp 11", i, {disp2rob_instr0_enq_valid, disp2intisq_enq_valid}); end
      step();
    end
    set_in(1, 0, 0, 2'b00, 2'b00);
    #1;
    checks++; if (isu2iru_instr0_ready !== 1'b0) begin failures++; $display("FAIL fill_stall_ready: got %0b exp 0", isu2iru_instr0_ready); end
    checks++; if (disp2intisq_enq_valid !== 1'b0) begin failures++; $display("FAIL fill_stall_enq: got %0b exp 0", disp2intisq_enq_valid); end
    checks++; if (rob_free !== 7'd56) begin failures++; $display("FAIL fill_rob: got %0d exp 56", rob_free); end
    // one dequeue frees exactly one more dispatch
    set_in(1, 0, 1, 2'b00, 2'b00);
    #1;
    checks++; if (isu2iru_instr0_ready !== 1'b0) begin failures++; $display("FAIL deq_ready: got %0b exp 0", isu2iru_instr0_ready); end
    step();
    checks++; if (isq_credit !== 4'd1) begin failures++; $display("FAIL deq_isq: got %0d exp 1", isq_credit); end
    set_in(1, 0, 0, 2'b00, 2'b00);
    #1;
    checks++; if (disp_fire !== 1'b1) begin failures++; $display("FAIL deq_fire: got %0b exp 1", disp_fire); end
    step();
    checks++; if (isq_credit !== 4'd0) begin failures++; $display("FAIL deq_isq_after: got %0d exp 0", isq_credit); end
    checks++; if (rob_free !== 7'd55) begin failures++; $display("FAIL deq_rob: got %0d exp 55", rob_free); end
  endtask

  task automatic test_fire_deq();
    repeat (3) begin set_in(0, 0, 1, 2'b00, 2'b00); step(); end
    checks++; if (isq_credit !== 4'd3) begin failures++; $display("FAIL fd_pre_isq: got %0d exp 3", isq_credit); end
    set_in(1, 0, 1, 2'b00, 2'b00);
    #1;
    checks++; if (disp_fire !== 1'b1) begin failures++; $display("FAIL fd_fire: got %0b exp 1", disp_fire); end
    step();
    checks++; if (isq_credit !== 4'd3) begin failures++; $display("FAIL fd_isq: got %0d exp 3", isq_credit); end
    checks++; if (rob_free !== 7'd54) begin failures++; $display("FAIL fd_rob: got %0d exp 54", rob_free); end
  endtask

  task automatic test_overflow();
    repeat (5) begin set_in(0, 0, 1, 2'b00, 2'b00); step(); end
    checks++; if (isq_credit !== 4'd8) begin failures++; $display("FAIL ovf_pre_isq: got %0d exp 8", isq_credit); end
    checks++; if (credit_err !== 1'b0) begin failures++; $display("FAIL ovf_pre_err: got %0b exp 0", credit_err); end
    set_in(0, 0, 1, 2'b00, 2'b00);
    step();
    checks++; if (isq_credit !== 4'd8) begin failures++; $display("FAIL ovf_isq: got %0d exp 8", isq_credit); end
    checks++; if (credit_err !== 1'b1) begin failures++; $display("FAIL ovf_err: got %0b exp 1", credit_err); end
    for (int i = 0; i < 3; i++) begin
      set_in(1, 0, 0, 2'b00, 2'b00);
      step();
      checks++; if (credit_err !== 1'b1) begin failures++; $display("FAIL ovf_sticky[%0d]: got %0b exp 1", i, credit_err); end
    end
    do_reset();
    checks++; if (credit_err !== 1'b0) begin failures++; $display("FAIL ovf_clear: got %0b exp 0", credit_err); end
  endtask

  task automatic test_flush_walk();
    logic [1:0] st_exp [7];
    logic [1:0] rs;
    st_exp = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd0};
    do_reset();
    repeat (3) begin set_in(1, 0, 0, 2'b00, 2'b00); step(); end
    set_in(1, 1, 1, 2'b01, 2'b00);
    #1;
    checks++; if (isu2iru_instr0_ready !== 1'b0) begin failures++; $display("FAIL fl_ready0: got %0b exp 0", isu2iru_instr0_ready); end
    checks++; if (disp_fire !== 1'b0) begin failures++; $display("FAIL fl_fire0: got %0b exp 0", disp_fire); end
    step();
    for (int c = 1; c <= 7; c++) begin
      rs = (c < 5) ? 2'b01 : 2'b00;
      set_in(1, 0, 0, rs, 2'b00);
      #1;
      checks++; if (disp_state !== st_exp[c-1]) begin failures++; $display("FAIL fl_state[%0d]: got %0d exp %0d", c, disp_state, st_exp[c-1]); end
      checks++; if (isu2iru_instr0_ready !== (c == 7)) begin failures++; $display("FAIL fl_ready[%0d]: got %0b exp %0b", c, isu2iru_instr0_ready, c == 7); end
      if (c == 1) begin
        checks++; if (isq_credit !== 4'd8) begin failures++; $display("FAIL fl_isq: got %0d exp 8", isq_credit); end
      end
      step();
    end
  endtask

  task automatic test_reset_midwalk();
    do_reset();
    repeat (6) begin set_in(1, 0, 0, 2'b00, 2'b00); step(); end
    checks++; if (isq_credit !== 4'd2) begin failures++; $display("FAIL rm_pre_isq: got %0d exp 2", isq_credit); end
    set_in(1, 0, 0, 2'b00, 2'b00);
    #2 reset = 1'b1;
    mdl_reset();
    #1;
    checks++; if (isq_credit !== 4'd8) begin failures++; $display("FAIL rm_isq: got %0d exp 8", isq_credit); end
    checks++; if (rob_free !== 7'd64) begin failures++; $display("FAIL rm_rob: got %0d exp 64", rob_free); end
    checks++; if (isu2iru_instr0_ready !== 1'b0) begin failures++; $display("FAIL rm_ready: got %0b exp 0", isu2iru_instr0_ready); end
    @(posedge clock); #1 reset = 1'b0;
    repeat (4) begin set_in(1, 0, 0, 2'b00, 2'b00); step(); end
    set_in(0, 1, 0, 2'b01, 2'b00); step();
    repeat (2) begin set_in(1, 0, 0, 2'b01, 2'b00); step(); end
    set_in(1, 0, 0, 2'b01, 2'b00);
    #1;
    checks++; if (disp_state !== 2'd2) begin failures++; $display("FAIL rw_pre_state: got %0d exp 2", disp_state); end
    checks++; if (rob_free !== 7'd60) begin failures++; $display("FAIL rw_pre_rob: got %0d exp 60", rob_free); end
    #1 reset = 1'b1;
    mdl_reset();
    #1;
    checks++; if (disp_state !== 2'd0) begin failures++; $display("FAIL rw_state: got %0d exp 0", disp_state); end
    checks++; if (rob_free !== 7'd64) begin failures++; $display("FAIL rw_rob: got %0d exp 64", rob_free); end
    checks++; if (isq_credit !== 4'd8) begin failures++; $display("FAIL rw_isq: got %0d exp 8", isq_credit); end
    set_in(1, 0, 0, 2'b00, 2'b00);
    #1;
    checks++; if (isu2iru_instr0_ready !== 1'b0) begin failures++; $display("FAIL rw_ready: got %0b exp 0", isu2iru_instr0_ready); end
    @(posedge clock); #1 reset = 1'b0;
  endtask

  task automatic test_random();
    bit exp_rdy, exp_fire;
    logic [1:0] rs, rc;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rs = ($urandom % 5 == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rc = ($urandom % 6 == 0) ? 2'($urandom_range(1, 2)) : 2'b00;
      set_in($urandom % 4 != 0, $urandom % 20 == 0, $urandom % 3 == 0, rs, rc);
      #1;
      exp_rdy = model_ready();
      exp_fire = exp_rdy && iru2isu_instr0_valid;
      checks++; if (isu2iru_instr0_ready !== exp_rdy) begin failures++; $display("FAIL rnd_ready[%0d]: got %0b exp %0b", i, isu2iru_instr0_ready, exp_rdy); end
      checks++; if ({disp_fire, disp2rob_instr0_enq_valid, disp2intisq_enq_valid} !== {3{exp_fire}}) begin failures++; $display("FAIL rnd_fire[%0d]: got %b exp %b", i, {disp_fire, disp2rob_instr0_enq_valid, disp2intisq_enq_valid}, {3{exp_fire}}); end
      checks++; if (isq_credit !== 4'(m_isq)) begin failures++; $display("FAIL rnd_isq[%0d]: got %0d exp %0d", i, isq_credit, m_isq); end
      checks++; if (rob_free !== 7'(m_rob)) begin failures++; $display("FAIL rnd_rob[%0d]: got %0d exp %0d", i, rob_free, m_rob); end
      checks++; if (disp_state !== 2'(m_mode)) begin failures++; $display("FAIL rnd_state[%0d]: got %0d exp %0d", i, disp_state, m_mode); end
      checks++; if (credit_err !== m_err) begin failures++; $display("FAIL rnd_err[%0d]: got %0b exp %0b", i, credit_err, m_err); end
      step();
    end
  endtask

  initial begin
    mdl_reset();
    test_reset();
    test_fill();
    test_fire_deq();
    test_overflow();
    test_flush_walk();
    test_reset_midwalk();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
